pipeif_fetch: RTL and testbench
===============================

Name: pipeif_fetch

Overview:
Instruction-fetch stage of the 5-stage pipelined CPU. It is the producer side of the IF/ID interface: it owns the PC, fetches words over a req/ack instruction-memory port, and registers inst/dpc4 for the decode stage. It consumes the decode stage's redirect outputs (pcsource, bpc, jpc, da) and its stall output (wpcir). Branches are delayed: the slot instruction always executes, and there is no flush.

Parameters:
RESET_PC, 32'h0000_0000, PC of the first fetch after reset
CNT_W, 32, width of bubble counter

Ports:
clock  in  1  system clock, all state on rising edge
resetn  in  1  asynchronous active-low reset
wpcir  in  1  decode stall; 1 = decode does not consume IF/ID this cycle
pcsource  in  2  00 pc+4, 01 bpc, 10 jr (rpc), 11 jpc
bpc  in  32  branch target from decode
jpc  in  32  jump target from decode
rpc  in  32  register target (decode da) for jr
imem_req  out  1  fetch request
imem_addr  out  32  word address of request (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle only
imem_rdata  in  32  fetched instruction
inst  out  32  IF/ID instruction to decode
dpc4  out  32  IF/ID PC+4 of inst
dvalid  out  1  inst is a real instruction (0 = bubble)
pc  out  32  current fetch PC
bubble_cnt  out  CNT_W  count of bubbles inserted into IF/ID

Behaviour:
- Reset (async, resetn=0) sets these values: pc=RESET_PC, inst=0, dpc4=0, dvalid=0, bubble_cnt=0, hold_valid=0, redir_valid=0, state=S_IDLE, imem_req=0.
- Define id_adv = ~wpcir. In an id_adv cycle, decode takes IF/ID.
- Define redirect = id_adv & dvalid & (pcsource != 00). The target is selected by pcsource (01 bpc, 10 rpc, 11 jpc).
- FSM states: S_IDLE, S_REQ, S_FULL.
  - S_IDLE: lasts 1 cycle after reset release, then goes to S_REQ.
  - S_REQ: imem_req=1 and imem_addr=pc. Both are held stable until imem_ack.
  - S_FULL: the hold buffer is occupied, and imem_req=0.
- S_REQ without ack:
  - pc is unchanged.
  - If redirect: redir_pc<=target and redir_valid<=1. A newer redirect overwrites.
- S_REQ with ack: fetched word w, with w_pc4 = pc+4.
  - Next pc is chosen in this priority order: target if redirect this cycle, else redir_pc if redir_valid (then clear redir_valid), else pc+4.
  - If id_adv: IF/ID<={w, w_pc4, 1}, and the state stays S_REQ.
  - If ~id_adv: hold<={w, w_pc4} and hold_valid<=1, and the state goes to S_FULL. IF/ID is unchanged.
- S_FULL:
  - If redirect: pc<=target directly.
  - If id_adv: IF/ID<=hold, hold_valid<=0, and the state goes to S_REQ.
  - If ~id_adv: the state stays S_FULL.
- IF/ID when id_adv and nothing to load (S_IDLE, or S_REQ without ack): IF/ID<={0, dpc4 unchanged, 0} and bubble_cnt increments. The bubble is inst=0, an sll $0 nop.
- When ~id_adv, IF/ID holds its value in every state.
- Delay slot:
  - A branch leaves decode while its slot is being fetched or held. The slot is delivered next, then the target.
  - A branch in a delay slot is unsupported; the later redirect wins.
- Arithmetic: pc+4 is modulo 2^32, so 0xFFFF_FFFC wraps to 0. bubble_cnt wraps at 2^CNT_W.
- Reset mid-fetch: any outstanding request is abandoned. imem_req drops immediately, and the ack of the abandoned request is not expected.

Test Plan:
1. Reset, then zero-wait memory (ack every request cycle), wpcir=0.
   - Cycle 0 is a bubble (bubble_cnt=1).
   - Then addr 0,4,8… and IF/ID gets words with dpc4=4,8,12…, dvalid=1.
2. beq at 0x10 taken with bpc=0x40, zero wait.
   - IF/ID sequence: 0x10, slot 0x14, then 0x40.
   - imem_addr goes 0x14 then 0x40.
3. Memory 3-cycle latency on the slot fetch while the branch leaves decode.
   - redir_valid is set and addr 0x14 stays stable.
   - After ack, the slot is delivered and the next addr is 0x40.
   - Two bubbles are counted.
4. wpcir=1 for 3 cycles with zero-wait memory.
   - Fetch of 0x18 lands in the hold buffer and the state goes to S_FULL with imem_req=0.
   - IF/ID is frozen.
   - On release, 0x18 is delivered and fetching resumes at 0x1C.
5. jr (pcsource=10, rpc=0x100) while in S_FULL.
   - The held slot is delivered.
   - The next request addr is 0x100.
6. Assert resetn=0 mid-wait (req pending at 0x20).
   - All outputs return to reset values asynchronously.
   - The first request after release is at RESET_PC.

Source files
------------

// File: rtl/pipeif_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port and
// registers inst/dpc4/dvalid for decode. Branches are delayed, so there is no flush:
// a redirect only retargets the fetch that comes after the slot instruction.
module pipeif_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             wpcir,
  input  logic [1:0]       pcsource,
  input  logic [31:0]      bpc,
  input  logic [31:0]      jpc,
  input  logic [31:0]      rpc,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      inst,
  output logic [31:0]      dpc4,
  output logic             dvalid,
  output logic [31:0]      pc,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FULL = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [31:0]      dpc4_q, dpc4_d;
  logic             dvalid_q, dvalid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0]      hold_inst_q, hold_inst_d;
  logic [31:0]      hold_pc4_q, hold_pc4_d;
  logic             hold_valid_q, hold_valid_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic             redir_valid_q, redir_valid_d;

  logic        id_adv;
  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  // Decode handshake, redirect qualification and target selection.
  always_comb begin
    id_adv   = ~wpcir;
    redirect = id_adv & dvalid_q & (pcsource != 2'b00);
    pc_plus4 = pc_q + 32'd4;
    unique case (pcsource)
      2'b01:   target = bpc;
      2'b10:   target = rpc;
      2'b11:   target = jpc;
      default: target = pc_plus4;
    endcase
  end

  // Next-state logic for the fetch FSM, PC, hold buffer and IF/ID register.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    dpc4_d        = dpc4_q;
    dvalid_d      = dvalid_q;
    bubble_cnt_d  = bubble_cnt_q;
    hold_inst_d   = hold_inst_q;
    hold_pc4_d    = hold_pc4_q;
    hold_valid_d  = hold_valid_q;
    redir_pc_d    = redir_pc_q;
    redir_valid_d = redir_valid_q;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (id_adv) begin
          inst_d       = 32'h0;
          dvalid_d     = 1'b0;
          bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
      end

      S_REQ: begin
        if (imem_ack) begin
          redir_valid_d = 1'b0;
          if (redirect) begin
            pc_d = target;
          end else if (redir_valid_q) begin
            pc_d = redir_pc_q;
          end else begin
            pc_d = pc_plus4;
          end
          if (id_adv) begin
            inst_d   = imem_rdata;
            dpc4_d   = pc_plus4;
            dvalid_d = 1'b1;
          end else begin
            hold_inst_d  = imem_rdata;
            hold_pc4_d   = pc_plus4;
            hold_valid_d = 1'b1;
            state_d      = S_FULL;
          end
        end else begin
          if (redirect) begin
            redir_pc_d    = target;
            redir_valid_d = 1'b1;
          end
          if (id_adv) begin
            inst_d       = 32'h0;
            dvalid_d     = 1'b0;
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
          end
        end
      end

      S_FULL: begin
        if (redirect) begin
          pc_d = target;
        end
        if (id_adv) begin
          inst_d       = hold_inst_q;
          dpc4_d       = hold_pc4_q;
          dvalid_d     = 1'b1;
          hold_valid_d = 1'b0;
          state_d      = S_REQ;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any outstanding request.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'h0;
      dpc4_q        <= 32'h0;
      dvalid_q      <= 1'b0;
      bubble_cnt_q  <= '0;
      hold_inst_q   <= 32'h0;
      hold_pc4_q    <= 32'h0;
      hold_valid_q  <= 1'b0;
      redir_pc_q    <= 32'h0;
      redir_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      dpc4_q        <= dpc4_d;
      dvalid_q      <= dvalid_d;
      bubble_cnt_q  <= bubble_cnt_d;
      hold_inst_q   <= hold_inst_d;
      hold_pc4_q    <= hold_pc4_d;
      hold_valid_q  <= hold_valid_d;
      redir_pc_q    <= redir_pc_d;
      redir_valid_q <= redir_valid_d;
    end
  end

  // The request is held stable for the whole S_REQ residency.
  always_comb begin
    imem_req   = (state_q == S_REQ);
    imem_addr  = pc_q;
    inst       = inst_q;
    dpc4       = dpc4_q;
    dvalid     = dvalid_q;
    pc         = pc_q;
    bubble_cnt = bubble_cnt_q;
  end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed testbench for the instruction-fetch stage.
module tb_pipeif_fetch;

  logic        clock;
  logic        resetn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc;
  logic [31:0] jpc;
  logic [31:0] rpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] dpc4;
  logic        dvalid;
  logic [31:0] pc;
  logic [31:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  pipeif_fetch #(
    .RESET_PC(32'h0000_0000),
    .CNT_W   (32)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .wpcir     (wpcir),
    .pcsource  (pcsource),
    .bpc       (bpc),
    .jpc       (jpc),
    .rpc       (rpc),
    .imem_req  (imem_req),
    .imem_addr (imem_addr),
    .imem_ack  (imem_ack),
    .imem_rdata(imem_rdata),
    .inst      (inst),
    .dpc4      (dpc4),
    .dvalid    (dvalid),
    .pc        (pc),
    .bubble_cnt(bubble_cnt)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Memory contents: each word encodes its own address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; wpcir = 1'b0; pcsource = 2'b00;
    bpc = 32'h0; jpc = 32'h0; rpc = 32'h0;
    imem_ack = 1'b0; imem_rdata = 32'h0;
    repeat (2) cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc: got %h expected 0", pc); end
    checks++; if (inst !== 32'h0) begin errors++; $display("[TB] FAIL reset_inst: got %h expected 0", inst); end
    checks++; if (dpc4 !== 32'h0) begin errors++; $display("[TB] FAIL reset_dpc4: got %h expected 0", dpc4); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_dvalid: got %b expected 0", dvalid); end
    checks++; if (bubble_cnt !== 32'h0) begin errors++; $display("[TB] FAIL reset_bubble: got %0d expected 0", bubble_cnt); end
    resetn = 1'b1;
    cycle();
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("[TB] FAIL idle_bubble: got %0d expected 1", bubble_cnt); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("[TB] FAIL idle_dvalid: got %b expected 0", dvalid); end
    checks++; if (imem_req !== 1'b1) begin errors++; $display("[TB] FAIL first_req: got %b expected 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL first_addr: got %h expected 0", imem_addr); end
  endtask

  task automatic test_sequential();
    for (int k = 0; k < 4; k++) begin
      logic [31:0] a;
      a = 32'(k * 4);
      checks++; if (imem_addr !== a) begin errors++; $display("[TB] FAIL seq_addr: got %h expected %h", imem_addr, a); end
      imem_ack = 1'b1; imem_rdata = mem_word(a);
      cycle();
      checks++; if (inst !== mem_word(a)) begin errors++; $display("[TB] FAIL seq_inst: got %h expected %h", inst, mem_word(a)); end
      checks++; if (dpc4 !== a + 32'd4) begin errors++; $display("[TB] FAIL seq_dpc4: got %h expected %h", dpc4, a + 32'd4); end
      checks++; if (dvalid !== 1'b1) begin errors++; $display("[TB] FAIL seq_dvalid: got %b expected 1", dvalid); end
      checks++; if (pc !== a + 32'd4) begin errors++; $display("[TB] FAIL seq_pc: got %h expected %h", pc, a + 32'd4); end
    end
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("[TB] FAIL seq_bubble: got %0d expected 1", bubble_cnt); end
  endtask

  task automatic test_branch();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h10); pcsource = 2'b00;
    cycle();
    checks++; if (inst !== mem_word(32'h10)) begin errors++; $display("[TB] FAIL br_inst: got %h expected %h", inst, mem_word(32'h10)); end
    checks++; if (imem_addr !== 32'h14) begin errors++; $display("[TB] FAIL br_slot_addr: got %h expected 14", imem_addr); end
    imem_rdata = mem_word(32'h14); pcsource = 2'b01; bpc = 32'h40;
    cycle();
    checks++; if (inst !== mem_word(32'h14)) begin errors++; $display("[TB] FAIL br_slot_inst: got %h expected %h", inst, mem_word(32'h14)); end
    checks++; if (dpc4 !== 32'h18) begin errors++; $display("[TB] FAIL br_slot_dpc4: got %h expected 18", dpc4); end
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("[TB] FAIL br_target_addr: got %h expected 40", imem_addr); end
    pcsource = 2'b00; bpc = 32'h0; imem_rdata = mem_word(32'h40);
    cycle();
    checks++; if (inst !== mem_word(32'h40)) begin errors++; $display("[TB] FAIL br_target_inst: got %h expected %h", inst, mem_word(32'h40)); end
    checks++; if (dpc4 !== 32'h44) begin errors++; $display("[TB] FAIL br_target_dpc4: got %h expected 44", dpc4); end
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("[TB] FAIL br_bubble: got %0d expected 1", bubble_cnt); end
  endtask

  task automatic test_slot_latency();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h44);
    cycle();
    imem_ack = 1'b0; imem_rdata = 32'h0; pcsource = 2'b01; bpc = 32'h80;
    cycle();
    checks++; if (dut.redir_valid_q !== 1'b1) begin errors++; $display("[TB] FAIL lat_redir_valid: got %b expected 1", dut.redir_valid_q); end
    checks++; if (dvalid !== 1'b0) begin errors++; $display("[TB] FAIL lat_dvalid: got %b expected 0", dvalid); end
    checks++; if (bubble_cnt !== 32'd2) begin errors++; $display("[TB] FAIL lat_bubble1: got %0d expected 2", bubble_cnt); end
    checks++; if (imem_addr !== 32'h48 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL lat_addr1: got %h req %b expected 48 req 1", imem_addr, imem_req); end
    pcsource = 2'b00; bpc = 32'h0;
    cycle();
    checks++; if (bubble_cnt !== 32'd3) begin errors++; $display("[TB] FAIL lat_bubble2: got %0d expected 3", bubble_cnt); end
    checks++; if (imem_addr !== 32'h48) begin errors++; $display("[TB] FAIL lat_addr2: got %h expected 48", imem_addr); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h48);
    cycle();
    checks++; if (inst !== mem_word(32'h48)) begin errors++; $display("[TB] FAIL lat_slot_inst: got %h expected %h", inst, mem_word(32'h48)); end
    checks++; if (dpc4 !== 32'h4C || dvalid !== 1'b1) begin errors++; $display("[TB] FAIL lat_slot_dpc4: got %h/%b expected 4c/1", dpc4, dvalid); end
    checks++; if (imem_addr !== 32'h80) begin errors++; $display("[TB] FAIL lat_target_addr: got %h expected 80", imem_addr); end
    checks++; if (dut.redir_valid_q !== 1'b0) begin errors++; $display("[TB] FAIL lat_redir_clear: got %b expected 0", dut.redir_valid_q); end
  endtask

  task automatic test_stall();
    wpcir = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'h80);
    cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req: got %b expected 0", imem_req); end
    checks++; if (dut.hold_valid_q !== 1'b1) begin errors++; $display("[TB] FAIL stall_hold: got %b expected 1", dut.hold_valid_q); end
    checks++; if (pc !== 32'h84) begin errors++; $display("[TB] FAIL stall_pc: got %h expected 84", pc); end
    imem_ack = 1'b0; imem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (inst !== mem_word(32'h48) || dpc4 !== 32'h4C) begin errors++; $display("[TB] FAIL stall_frozen: got %h/%h expected %h/4c", inst, dpc4, mem_word(32'h48)); end
      if (i < 2) begin
        cycle();
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_req_held: got %b expected 0", imem_req); end
      end
    end
    wpcir = 1'b0;
    cycle();
    checks++; if (inst !== mem_word(32'h80) || dpc4 !== 32'h84) begin errors++; $display("[TB] FAIL stall_release: got %h/%h expected %h/84", inst, dpc4, mem_word(32'h80)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h84) begin errors++; $display("[TB] FAIL stall_resume: got req %b addr %h expected 1/84", imem_req, imem_addr); end
    checks++; if (bubble_cnt !== 32'd3) begin errors++; $display("[TB] FAIL stall_bubble: got %0d expected 3", bubble_cnt); end
    imem_ack = 1'b1; imem_rdata = mem_word(32'h84);
    cycle();
    checks++; if (inst !== mem_word(32'h84) || pc !== 32'h88) begin errors++; $display("[TB] FAIL stall_next: got %h pc %h expected %h pc 88", inst, pc, mem_word(32'h84)); end
  endtask

  task automatic test_jr_full();
    wpcir = 1'b1; imem_ack = 1'b1; imem_rdata = mem_word(32'h88);
    cycle();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL jr_full_req: got %b expected 0", imem_req); end
    wpcir = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0; pcsource = 2'b10; rpc = 32'h100;
    cycle();
    checks++; if (inst !== mem_word(32'h88) || dpc4 !== 32'h8C) begin errors++; $display("[TB] FAIL jr_slot: got %h/%h expected %h/8c", inst, dpc4, mem_word(32'h88)); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("[TB] FAIL jr_addr: got req %b addr %h expected 1/100", imem_req, imem_addr); end
    pcsource = 2'b00; rpc = 32'h0; imem_ack = 1'b1; imem_rdata = mem_word(32'h100);
    cycle();
    checks++; if (inst !== mem_word(32'h100) || pc !== 32'h104) begin errors++; $display("[TB] FAIL jr_target: got %h pc %h expected %h pc 104", inst, pc, mem_word(32'h100)); end
  endtask

  task automatic test_wrap();
    imem_rdata = mem_word(32'h104); pcsource = 2'b11; jpc = 32'hFFFF_FFFC;
    cycle();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_jpc: got %h expected fffffffc", pc); end
    pcsource = 2'b00; jpc = 32'h0; imem_rdata = mem_word(32'hFFFF_FFFC);
    cycle();
    checks++; if (dpc4 !== 32'h0 || inst !== mem_word(32'hFFFF_FFFC)) begin errors++; $display("[TB] FAIL wrap_dpc4: got %h/%h expected 0/%h", dpc4, inst, mem_word(32'hFFFF_FFFC)); end
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL wrap_pc: got %h expected 0", pc); end
  endtask

  task automatic test_reset_mid_fetch();
    imem_ack = 1'b1; imem_rdata = mem_word(32'h0);
    cycle();
    imem_ack = 1'b0; imem_rdata = 32'h0;
    cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("[TB] FAIL mid_pending: got req %b addr %h expected 1/4", imem_req, imem_addr); end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mid_req: got %b expected 0", imem_req); end
    checks++; if (pc !== 32'h0 || inst !== 32'h0 || dpc4 !== 32'h0) begin errors++; $display("[TB] FAIL mid_regs: got pc %h inst %h dpc4 %h expected 0", pc, inst, dpc4); end
    checks++; if (dvalid !== 1'b0 || bubble_cnt !== 32'h0) begin errors++; $display("[TB] FAIL mid_flags: got dvalid %b bubble %0d expected 0/0", dvalid, bubble_cnt); end
    cycle();
    resetn = 1'b1;
    cycle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("[TB] FAIL mid_restart: got req %b addr %h expected 1/0", imem_req, imem_addr); end
    checks++; if (bubble_cnt !== 32'd1) begin errors++; $display("[TB] FAIL mid_bubble: got %0d expected 1", bubble_cnt); end
  endtask

  // Scenario sequence.
  initial begin
    test_reset();
    test_sequential();
    test_branch();
    test_slot_latency();
    test_stall();
    test_jr_full();
    test_wrap();
    test_reset_mid_fetch();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
